layer_result_collector: RTL and testbench

LAYER_RESULT_COLLECTOR -- requirements
Module: layer_result_collector

---
 rtl/layer_result_collector.sv | 137 +++++++++++++
 tb/tb_layer_result_collector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_result_collector.sv
// rtl/layer_result_collector.sv - eight-beat pass tracker that queues MAC results in a small FIFO
// Optional beat-sequence checking is enabled by defining COLLECTOR_PROTO_CHECK_EN.
module layer_result_collector #(
   parameter int ACC_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [3:0]                  valid_ctrl,
   input  logic [2*ACC_W-1:0]          acc_in,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [2*ACC_W-1:0]          out_data,
   output logic [1:0]                  out_tag,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        pass_done,
   output logic                        ovf,
   output logic                        proto_err
);
   localparam int         AW     = $clog2(FIFO_DEPTH);
   localparam logic [3:0] C_LOAD = 4'b0011;
   localparam logic [3:0] C_SWAP = 4'b1100;
   localparam logic [3:0] C_NONE = 4'b0000;

   typedef enum logic [2:0] {
      S_IDLE, S_MAC0, S_W_SWAP0, S_MAC1, S_W_LOAD1, S_MAC2, S_W_SWAP1, S_MAC3
   } state_t;

   state_t             r_state;
   logic               r_pass_done;
   logic               r_ovf;
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic [2*ACC_W+1:0] r_mem [FIFO_DEPTH];

   logic               w_push;
   logic [1:0]         w_push_tag;
   logic               w_pop;
   logic               w_full;
   logic               w_push_ok;
   logic               w_bad;
   logic [2*ACC_W+1:0] w_head;

   always_comb begin
      w_push     = 1'b0;
      w_push_tag = 2'd0;
      case (r_state)
         S_MAC0:  begin w_push = 1'b1; w_push_tag = 2'd0; end
         S_MAC1:  begin w_push = 1'b1; w_push_tag = 2'd1; end
         S_MAC2:  begin w_push = 1'b1; w_push_tag = 2'd2; end
         S_MAC3:  begin w_push = 1'b1; w_push_tag = 2'd3; end
         default: ;
      endcase
   end

   always_comb begin
      w_bad = 1'b0;
`ifdef COLLECTOR_PROTO_CHECK_EN
      case (r_state)
         S_IDLE:               w_bad = (valid_ctrl != C_NONE) && (valid_ctrl != C_LOAD);
         S_W_SWAP0, S_W_SWAP1: w_bad = (valid_ctrl != C_SWAP);
         S_W_LOAD1:            w_bad = (valid_ctrl != C_LOAD);
         default:              w_bad = (valid_ctrl != C_NONE);
      endcase
`endif
   end

   // A MAC beat still captures even when its own code is illegal; only the tracker aborts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pass_done <= 1'b0;
      end else begin
         r_pass_done <= (r_state == S_MAC3) && !w_bad;
         if (w_bad) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE:    if (valid_ctrl == C_LOAD) r_state <= S_MAC0;
               S_MAC0:    r_state <= S_W_SWAP0;
               S_W_SWAP0: if (valid_ctrl == C_SWAP) r_state <= S_MAC1;
               S_MAC1:    r_state <= S_W_LOAD1;
               S_W_LOAD1: if (valid_ctrl == C_LOAD) r_state <= S_MAC2;
               S_MAC2:    r_state <= S_W_SWAP1;
               S_W_SWAP1: if (valid_ctrl == C_SWAP) r_state <= S_MAC3;
               default:   r_state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef COLLECTOR_PROTO_CHECK_EN
   logic r_proto_err;

   always_ff @(posedge clk) begin
      if (!rst_n)     r_proto_err <= 1'b0;
      else if (w_bad) r_proto_err <= 1'b1;
   end

   assign proto_err = r_proto_err;
`else
   assign proto_err = 1'b0;
`endif

   assign out_valid = (r_count != '0);
   assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_pop     = out_valid && out_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
         if (w_push && !w_push_ok)     r_ovf   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= {w_push_tag, acc_in};
   end

   // Storage is not cleared by reset, so the head is masked while the FIFO is empty.
   assign w_head     = r_mem[r_rd_ptr];
   assign out_data   = out_valid ? w_head[2*ACC_W-1:0] : '0;
   assign out_tag    = out_valid ? w_head[2*ACC_W+1 -: 2] : 2'd0;
   assign fifo_level = r_count;
   assign pass_done  = r_pass_done;
   assign ovf        = r_ovf;
endmodule

// File: tb/tb_layer_result_collector.sv
// tb/tb_layer_result_collector.sv - directed checks for layer_result_collector at FIFO depths 4 and 2
module tb_layer_result_collector;
   localparam logic [3:0]  LD   = 4'b0011;
   localparam logic [3:0]  SW   = 4'b1100;
   localparam logic [3:0]  NOP  = 4'b0000;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
`ifdef COLLECTOR_PROTO_CHECK_EN
   localparam logic       EXP_PE  = 1'b1;
   localparam int         EXP_PD  = 0;
   localparam logic [1:0] EXP_TAG = 2'd1;
`else
   localparam logic       EXP_PE  = 1'b0;
   localparam int         EXP_PD  = 1;
   localparam logic [1:0] EXP_TAG = 2'd3;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  valid_ctrl;
   logic [31:0] acc_in;
   logic        rdy4, rdy2;
   logic        v4, pd4, ovf4, pe4, v2, pd2, ovf2, pe2;
   logic [31:0] d4, d2;
   logic [1:0]  t4, t2;
   logic [2:0]  l4;
   logic [1:0]  l2;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [3:0]  pass_codes [8] = '{LD, NOP, SW, NOP, LD, NOP, SW, NOP};

   always #5 clk = ~clk;

   layer_result_collector u_dut4 (
      .clk(clk), .rst_n(rst_n), .valid_ctrl(valid_ctrl), .acc_in(acc_in), .out_ready(rdy4),
      .out_valid(v4), .out_data(d4), .out_tag(t4), .fifo_level(l4),
      .pass_done(pd4), .ovf(ovf4), .proto_err(pe4)
   );

   layer_result_collector #(.ACC_W(16), .FIFO_DEPTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .valid_ctrl(valid_ctrl), .acc_in(acc_in), .out_ready(rdy2),
      .out_valid(v2), .out_data(d2), .out_tag(t2), .fifo_level(l2),
      .pass_done(pd2), .ovf(ovf2), .proto_err(pe2)
   );

   task automatic beat(input logic [3:0] code, input logic [31:0] data);
      valid_ctrl = code;
      acc_in     = data;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      beat(NOP, JUNK);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rdy4 = 1'b0; rdy2 = 1'b0;
      beat(NOP, 32'h0);
      beat(NOP, 32'h0);
      rst_n = 1'b1;
      n_tests++;
      if ({v4, pd4, ovf4, pe4} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags4: got v/pd/ovf/pe=%b want 0000", {v4, pd4, ovf4, pe4});
      end
      n_tests++;
      if (d4 !== 32'h0 || t4 !== 2'd0 || l4 !== 3'd0) begin
         n_fail++; $display("FAIL reset_head4: got data=%h tag=%0d level=%0d want 0 0 0", d4, t4, l4);
      end
      n_tests++;
      if ({v2, pd2, ovf2, pe2} !== 4'b0 || l2 !== 2'd0) begin
         n_fail++; $display("FAIL reset_dut2: got flags=%b level=%0d want 0000 0", {v2, pd2, ovf2, pe2}, l2);
      end
   endtask

   task automatic test_pass();
      do_reset();
      rdy4 = 1'b1; rdy2 = 1'b1;
      for (int b = 0; b < 8; b++) begin
         beat(pass_codes[b], (b % 2 == 1) ? 32'((b / 2) * 17) : JUNK);
         n_tests++;
         if (b % 2 == 1) begin
            if (v4 !== 1'b1 || t4 !== 2'(b / 2) || d4 !== 32'((b / 2) * 17)) begin
               n_fail++;
               $display("FAIL pass_head beat %0d: got v=%b tag=%0d data=%h want 1 %0d %h",
                        b, v4, t4, d4, b / 2, (b / 2) * 17);
            end
         end else if (v4 !== 1'b0) begin
            n_fail++; $display("FAIL pass_drained beat %0d: got v=%b want 0", b, v4);
         end
         n_tests++;
         if (pd4 !== 1'(b == 7)) begin
            n_fail++; $display("FAIL pass_done beat %0d: got %b want %b", b, pd4, (b == 7));
         end
      end
      beat(NOP, JUNK);
      n_tests++;
      if (pd4 !== 1'b0 || v4 !== 1'b0 || l4 !== 3'd0) begin
         n_fail++; $display("FAIL pass_end: got pd=%b v=%b level=%0d want 0 0 0", pd4, v4, l4);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      rdy4 = 1'b1; rdy2 = 1'b0;
      for (int b = 0; b < 8; b++) begin
         beat(pass_codes[b], (b % 2 == 1) ? 32'((b / 2) * 17) : JUNK);
         n_tests++;
         if (l2 !== ((b == 0) ? 2'd0 : (b < 3) ? 2'd1 : 2'd2) || ovf2 !== 1'(b >= 5)) begin
            n_fail++; $display("FAIL ovf_level beat %0d: got level=%0d ovf=%b want %0d %b",
                               b, l2, ovf2, (b == 0) ? 0 : (b < 3) ? 1 : 2, (b >= 5));
         end
         if (b >= 1) begin
            n_tests++;
            if (v2 !== 1'b1 || t2 !== 2'd0 || d2 !== 32'h0) begin
               n_fail++; $display("FAIL ovf_head beat %0d: got v=%b tag=%0d data=%h want 1 0 0", b, v2, t2, d2);
            end
         end
      end
      rdy2 = 1'b1;
      beat(NOP, JUNK);
      n_tests++;
      if (t2 !== 2'd1 || d2 !== 32'h11 || l2 !== 2'd1) begin
         n_fail++; $display("FAIL ovf_drain1: got tag=%0d data=%h level=%0d want 1 11 1", t2, d2, l2);
      end
      beat(NOP, JUNK);
      n_tests++;
      if (v2 !== 1'b0 || l2 !== 2'd0 || ovf2 !== 1'b1) begin
         n_fail++; $display("FAIL ovf_drain2: got v=%b level=%0d ovf=%b want 0 0 1", v2, l2, ovf2);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      rdy4 = 1'b1; rdy2 = 1'b0;
      for (int b = 0; b < 5; b++) beat(pass_codes[b], (b % 2 == 1) ? 32'((b / 2) * 17) : JUNK);
      rdy2 = 1'b1;
      beat(NOP, 32'h22);
      n_tests++;
      if (l2 !== 2'd2 || t2 !== 2'd1 || d2 !== 32'h11 || ovf2 !== 1'b0) begin
         n_fail++; $display("FAIL pp_mac2: got level=%0d tag=%0d data=%h ovf=%b want 2 1 11 0", l2, t2, d2, ovf2);
      end
      rdy2 = 1'b0;
      beat(SW, JUNK);
      n_tests++;
      if (l2 !== 2'd2 || t2 !== 2'd1 || d2 !== 32'h11) begin
         n_fail++; $display("FAIL pp_hold: got level=%0d tag=%0d data=%h want 2 1 11", l2, t2, d2);
      end
      rdy2 = 1'b1;
      beat(NOP, 32'h33);
      n_tests++;
      if (l2 !== 2'd2 || t2 !== 2'd2 || d2 !== 32'h22 || ovf2 !== 1'b0 || pd2 !== 1'b1) begin
         n_fail++; $display("FAIL pp_mac3: got level=%0d tag=%0d data=%h ovf=%b pd=%b want 2 2 22 0 1",
                            l2, t2, d2, ovf2, pd2);
      end
      beat(NOP, JUNK);
      n_tests++;
      if (l2 !== 2'd1 || t2 !== 2'd3 || d2 !== 32'h33) begin
         n_fail++; $display("FAIL pp_drain: got level=%0d tag=%0d data=%h want 1 3 33", l2, t2, d2);
      end
   endtask

   task automatic test_proto();
      logic [3:0]  seq_c [7] = '{SW, NOP, LD, NOP, SW, NOP, NOP};
      logic [31:0] seq_d [7] = '{JUNK, 32'h11, JUNK, 32'h22, JUNK, 32'h33, JUNK};
      int          pd_cnt = 0;
      do_reset();
      rdy4 = 1'b1; rdy2 = 1'b1;
      beat(LD, JUNK);
      beat(SW, 32'h0);
      n_tests++;
      if (v4 !== 1'b1 || t4 !== 2'd0 || d4 !== 32'h0 || pe4 !== EXP_PE) begin
         n_fail++; $display("FAIL proto_capture: got v=%b tag=%0d data=%h pe=%b want 1 0 0 %b",
                            v4, t4, d4, pe4, EXP_PE);
      end
      for (int i = 0; i < 7; i++) begin
         beat(seq_c[i], seq_d[i]);
         if (pd4 === 1'b1) pd_cnt++;
         if (i == 5) begin
            n_tests++;
            if (t4 !== EXP_TAG || d4 !== 32'h33) begin
               n_fail++; $display("FAIL proto_late_tag: got tag=%0d data=%h want %0d 33", t4, d4, EXP_TAG);
            end
         end
      end
      n_tests++;
      if (pd_cnt != EXP_PD || pe4 !== EXP_PE) begin
         n_fail++; $display("FAIL proto_outcome: got pass_done pulses=%0d pe=%b want %0d %b",
                            pd_cnt, pe4, EXP_PD, EXP_PE);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      rdy4 = 1'b0; rdy2 = 1'b0;
      for (int b = 0; b < 4; b++) beat(pass_codes[b], (b % 2 == 1) ? 32'((b / 2) * 17) : JUNK);
      n_tests++;
      if (l4 !== 3'd2) begin
         n_fail++; $display("FAIL mid_prefill: got level=%0d want 2", l4);
      end
      rst_n = 1'b0;
      beat(NOP, JUNK);
      rst_n = 1'b1;
      n_tests++;
      if (l4 !== 3'd0 || v4 !== 1'b0 || d4 !== 32'h0 || l2 !== 2'd0 || pd4 !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got level=%0d v=%b data=%h level2=%0d pd=%b want 0 0 0 0 0",
                            l4, v4, d4, l2, pd4);
      end
      rdy4 = 1'b1;
      for (int b = 0; b < 8; b++) begin
         beat(pass_codes[b], (b % 2 == 1) ? 32'((b / 2) * 17 + 5) : JUNK);
         if (b % 2 == 1) begin
            n_tests++;
            if (v4 !== 1'b1 || t4 !== 2'(b / 2) || d4 !== 32'((b / 2) * 17 + 5) || pd4 !== 1'(b == 7)) begin
               n_fail++; $display("FAIL mid_repass beat %0d: got v=%b tag=%0d data=%h pd=%b want 1 %0d %h %b",
                                  b, v4, t4, d4, pd4, b / 2, (b / 2) * 17 + 5, (b == 7));
            end
         end
      end
   endtask

   initial begin
      valid_ctrl = NOP; acc_in = 32'h0; rst_n = 1'b0; rdy4 = 1'b0; rdy2 = 1'b0;
      test_reset();
      test_pass();
      test_overflow();
      test_push_pop();
      test_proto();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
